tipi_chan_bank: RTL and testbench

//  Clocked, multi-channel successor to the TI<->RPi register exchange in tipi_top.
//  NUM_CH channels, each with four byte registers:
//   RD/RC = RPi->TI data/control, read-only from the TI.
//   TD/TC = TI->RPi data/control, TI-writable.
//  TI side: memory-mapped parallel bus. RPi side: serial r_clk/r_le bus.
//  All RPi and TI strobes are synchronised into one clock domain and edge-detected;

---
 rtl/tipi_chan_bank_if.sv | 33 +++
 rtl/tipi_chan_bank.sv | 176 +++++++++++++++++
 tb/tb_tipi_chan_bank.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/tipi_chan_bank_if.sv
// TI parallel bus and RPi serial bus signals of one tipi_chan_bank instance.
// master = board/bench side driving the pins, slave = the register bank.
interface tipi_chan_bank_if #(
   parameter int SEL_W = 1
);
   logic [0:15]      ti_a;
   logic             ti_memen;
   logic             ti_we;
   logic             ti_dbin;
   logic [0:7]       ti_d_in;
   logic [0:7]       ti_d_out;
   logic             ti_d_oe;
   logic             r_clk;
   logic             r_le;
   logic             r_rt;
   logic             r_dc;
   logic [SEL_W-1:0] r_sel;
   logic             r_dout;
   logic             r_din;
   logic             ti_extint;

   modport master (
      output ti_a, ti_memen, ti_we, ti_dbin, ti_d_in,
      output r_clk, r_le, r_rt, r_dc, r_sel, r_dout,
      input  ti_d_out, ti_d_oe, r_din, ti_extint
   );

   modport slave (
      input  ti_a, ti_memen, ti_we, ti_dbin, ti_d_in,
      input  r_clk, r_le, r_rt, r_dc, r_sel, r_dout,
      output ti_d_out, ti_d_oe, r_din, ti_extint
   );
endinterface

// File: rtl/tipi_chan_bank.sv
// tipi_chan_bank: NUM_CH-channel TI<->RPi byte register exchange in a single clock domain.
// Define TIPI_RC_IRQ_EN to add the per-channel RC-written interrupt (ti_extint).
module tipi_chan_bank #(
   parameter int          NUM_CH      = 1,
   parameter int          SEL_W       = 1,
   parameter logic [15:0] BASE_ADDR   = 16'h5FF8,
   parameter int          SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dev_en,
   input  logic            irq_en,
   tipi_chan_bank_if.slave bus
);
   localparam int NA = 6;

   function automatic logic [15:0] reg_addr(input int c, input int off);
      return BASE_ADDR - 16'(8 * c) + 16'(off);
   endfunction

   logic [0:7]       r_rd [NUM_CH];
   logic [0:7]       r_rc [NUM_CH];
   logic [0:7]       r_td [NUM_CH];
   logic [0:7]       r_tc [NUM_CH];
   logic [0:7]       r_sr_in;
   logic [0:7]       r_sr_out;
   logic             r_din;
   logic [NA-1:0]    r_sync [SYNC_STAGES];
   logic [SEL_W-1:0] r_sel_sync [SYNC_STAGES];
   logic [2:0]       r_edge_d;

   logic              w_ws;
   logic [NA-1:0]     w_async;
   logic [NA-1:0]     w_s;
   logic [SEL_W-1:0]  w_sel;
   logic              w_shift;
   logic              w_latch;
   logic              w_wr;
   logic              w_rt;
   logic              w_dc;
   logic              w_dout;
   logic [NUM_CH-1:0] w_lsel;
   logic              w_hit;
   logic [0:7]        w_rdata;
   logic              w_rd_en;

   // Every async pin, including the gated TI write strobe, goes through the same depth
   // so the RPi data/qualifier bits line up with their strobe edges.
   assign w_ws    = dev_en & ~bus.ti_memen & ~bus.ti_we;
   assign w_async = {bus.r_dout, bus.r_dc, bus.r_rt, w_ws, bus.r_le, bus.r_clk};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i]     <= '0;
            r_sel_sync[i] <= '0;
         end
         r_edge_d <= '0;
      end else begin
         r_sync[0]     <= w_async;
         r_sel_sync[0] <= bus.r_sel;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i]     <= r_sync[i-1];
            r_sel_sync[i] <= r_sel_sync[i-1];
         end
         r_edge_d <= r_sync[SYNC_STAGES-1][2:0];
      end
   end

   assign w_s     = r_sync[SYNC_STAGES-1];
   assign w_sel   = r_sel_sync[SYNC_STAGES-1];
   assign w_shift = w_s[0] & ~r_edge_d[0];
   assign w_latch = w_s[1] & ~r_edge_d[1];
   assign w_wr    = w_s[2] & ~r_edge_d[2];
   assign w_rt    = w_s[3];
   assign w_dc    = w_s[4];
   assign w_dout  = w_s[5];

   always_comb begin
      w_lsel = '0;
      for (int c = 0; c < NUM_CH; c++)
         w_lsel[c] = w_latch & (int'(w_sel) == c);
   end

   always_comb begin
      w_hit   = 1'b0;
      w_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (bus.ti_a == reg_addr(c, 1)) begin w_hit = 1'b1; w_rdata = r_rc[c]; end
         if (bus.ti_a == reg_addr(c, 3)) begin w_hit = 1'b1; w_rdata = r_rd[c]; end
         if (bus.ti_a == reg_addr(c, 5)) begin w_hit = 1'b1; w_rdata = r_tc[c]; end
         if (bus.ti_a == reg_addr(c, 7)) begin w_hit = 1'b1; w_rdata = r_td[c]; end
      end
   end

   assign w_rd_en      = w_hit & dev_en & ~bus.ti_memen & bus.ti_dbin;
   assign bus.ti_d_oe  = w_rd_en;
   assign bus.ti_d_out = w_rd_en ? w_rdata : 8'h00;

   // A latch event (even one with an out-of-range r_sel) swallows a coincident shift.
   // sr_out loads read the T registers before this cycle's TI write lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_rd[c] <= '0;
            r_rc[c] <= '0;
            r_td[c] <= '0;
            r_tc[c] <= '0;
         end
         r_sr_in  <= '0;
         r_sr_out <= '0;
         r_din    <= 1'b0;
      end else begin
         r_din <= r_sr_out[0];
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr && bus.ti_a == reg_addr(c, 5)) r_tc[c] <= bus.ti_d_in;
            if (w_wr && bus.ti_a == reg_addr(c, 7)) r_td[c] <= bus.ti_d_in;
            if (w_lsel[c] && !w_rt && w_dc)  r_rc[c] <= r_sr_in;
            if (w_lsel[c] && !w_rt && !w_dc) r_rd[c] <= r_sr_in;
            if (w_lsel[c] && w_rt)           r_sr_out <= w_dc ? r_tc[c] : r_td[c];
         end
         if (w_shift && !w_latch) begin
            r_sr_in  <= {r_sr_in[1:7], w_dout};
            r_sr_out <= {r_sr_out[1:7], 1'b0};
         end
      end
   end

   assign bus.r_din = r_din;

`ifdef TIPI_RC_IRQ_EN
   logic [NUM_CH-1:0] w_rc_rd;
   logic [NUM_CH-1:0] w_rc_set;
   logic [NUM_CH-1:0] r_rcrd_sync [SYNC_STAGES];
   logic [NUM_CH-1:0] r_rcrd_d;
   logic [NUM_CH-1:0] r_pending;
   logic              r_extint;

   // Clear is keyed per channel on the synchronised read strobe, so a TI address
   // change after the strobe drops cannot redirect it.
   always_comb begin
      w_rc_rd  = '0;
      w_rc_set = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_rc_rd[c]  = dev_en & ~bus.ti_memen & bus.ti_dbin & (bus.ti_a == reg_addr(c, 1));
         w_rc_set[c] = w_lsel[c] & ~w_rt & w_dc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_rcrd_sync[i] <= '0;
         r_rcrd_d  <= '0;
         r_pending <= '0;
         r_extint  <= 1'b1;
      end else begin
         r_rcrd_sync[0] <= w_rc_rd;
         for (int i = 1; i < SYNC_STAGES; i++) r_rcrd_sync[i] <= r_rcrd_sync[i-1];
         r_rcrd_d <= r_rcrd_sync[SYNC_STAGES-1];
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_rc_set[c])
               r_pending[c] <= 1'b1;
            else if (r_rcrd_d[c] && !r_rcrd_sync[SYNC_STAGES-1][c])
               r_pending[c] <= 1'b0;
         end
         r_extint <= ~(irq_en & |r_pending);
      end
   end

   assign bus.ti_extint = r_extint;
`else
   logic w_unused_irq;
   assign w_unused_irq  = irq_en;
   assign bus.ti_extint = 1'b1;
`endif
endmodule

// File: tb/tb_tipi_chan_bank.sv
// Directed bench for tipi_chan_bank, two channels, SEL_W=2, SYNC_STAGES=2.
// Covers the RC interrupt when TIPI_RC_IRQ_EN is defined, else checks ti_extint stays high.
module tb_tipi_chan_bank;
   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic dev_en = 1'b0;
   logic irq_en = 1'b0;
   int   n_chk  = 0;
   int   n_bad  = 0;
   logic [7:0] rb;

   tipi_chan_bank_if #(.SEL_W(2)) bus ();

   tipi_chan_bank #(
      .NUM_CH(2), .SEL_W(2), .BASE_ADDR(16'h5FF8), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .dev_en(dev_en), .irq_en(irq_en), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ti_write(input logic [15:0] a, input logic [7:0] d);
      bus.ti_a = a; bus.ti_d_in = d; bus.ti_memen = 1'b0; bus.ti_we = 1'b0;
      cyc(5);
      bus.ti_we = 1'b1; bus.ti_memen = 1'b1;
      cyc(5);
   endtask

   task automatic ti_read(input string tag, input logic [15:0] a, input logic oe, input logic [7:0] d);
      bus.ti_a = a; bus.ti_memen = 1'b0; bus.ti_dbin = 1'b1;
      cyc(2);
      #1;
      chk({tag, "_oe"}, 16'(bus.ti_d_oe), 16'(oe));
      chk({tag, "_d"}, 16'(bus.ti_d_out), 16'(d));
      bus.ti_dbin = 1'b0; bus.ti_memen = 1'b1;
      cyc(5);
   endtask

   task automatic rpi_shift(input logic b);
      bus.r_dout = b;
      cyc(4);
      bus.r_clk = 1'b1;
      cyc(4);
      bus.r_clk = 1'b0;
      cyc(4);
   endtask

   task automatic rpi_shift_byte(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) rpi_shift(d[i]);
   endtask

   task automatic rpi_latch(input logic rt, input logic dc, input logic [1:0] sel);
      bus.r_rt = rt; bus.r_dc = dc; bus.r_sel = sel;
      cyc(4);
      bus.r_le = 1'b1;
      cyc(4);
      bus.r_le = 1'b0;
      cyc(4);
   endtask

   task automatic rpi_read_byte(output logic [7:0] d);
      d = '0;
      for (int i = 7; i >= 0; i--) begin
         d[i] = bus.r_din;
         rpi_shift(1'b0);
      end
   endtask

   initial begin
      bus.ti_a = '0; bus.ti_memen = 1'b1; bus.ti_we = 1'b1; bus.ti_dbin = 1'b0;
      bus.ti_d_in = '0; bus.r_clk = 1'b0; bus.r_le = 1'b0; bus.r_rt = 1'b0;
      bus.r_dc = 1'b0; bus.r_sel = '0; bus.r_dout = 1'b0;

      // reset state
      cyc(3);
      chk("rst_oe", 16'(bus.ti_d_oe), 16'h0);
      chk("rst_dout", 16'(bus.ti_d_out), 16'h0);
      chk("rst_rdin", 16'(bus.r_din), 16'h0);
      chk("rst_extint", 16'(bus.ti_extint), 16'h1);
      rst_n = 1'b1; dev_en = 1'b1;
      cyc(3);
      ti_read("rst_td0", 16'h5FFF, 1'b1, 8'h00);

      // TI -> RPi: TD ch0 = A5, shifted out MSB first
      ti_write(16'h5FFF, 8'hA5);
      ti_read("td0", 16'h5FFF, 1'b1, 8'hA5);
      rpi_latch(1'b1, 1'b0, 2'd0);
      rpi_read_byte(rb);
      chk("sr_out_a5", 16'(rb), 16'h00A5);

      // RPi -> TI: RC ch0 = 3C
      rpi_shift_byte(8'h3C);
      rpi_latch(1'b0, 1'b1, 2'd0);
      chk("extint_irqoff", 16'(bus.ti_extint), 16'h1);
      ti_read("rc0", 16'h5FF9, 1'b1, 8'h3C);
      ti_read("rd0_zero", 16'h5FFB, 1'b1, 8'h00);

      // two channels, out-of-range select
      rpi_shift_byte(8'h11);
      rpi_latch(1'b0, 1'b0, 2'd0);
      rpi_shift_byte(8'h22);
      rpi_latch(1'b0, 1'b0, 2'd1);
      ti_read("rd0", 16'h5FFB, 1'b1, 8'h11);
      ti_read("rd1", 16'h5FF3, 1'b1, 8'h22);
      rpi_shift_byte(8'h77);
      rpi_latch(1'b0, 1'b0, 2'd3);
      rpi_latch(1'b0, 1'b1, 2'd2);
      ti_read("rd0_sel3", 16'h5FFB, 1'b1, 8'h11);
      ti_read("rd1_sel3", 16'h5FF3, 1'b1, 8'h22);
      ti_read("rc1_sel2", 16'h5FF1, 1'b1, 8'h00);

      // decode boundaries and write gating
      ti_read("even_addr", 16'h5FFA, 1'b0, 8'h00);
      ti_read("below_ch1", 16'h5FEF, 1'b0, 8'h00);
      dev_en = 1'b0;
      ti_write(16'h5FFD, 8'hFF);
      ti_read("dis_rd", 16'h5FFD, 1'b0, 8'h00);
      dev_en = 1'b1;
      ti_read("tc0_dis", 16'h5FFD, 1'b1, 8'h00);
      ti_write(16'h5FFB, 8'hEE);
      ti_read("rd0_ro", 16'h5FFB, 1'b1, 8'h11);
      ti_write(16'h5FF5, 8'h9C);
      rpi_latch(1'b1, 1'b1, 2'd1);
      rpi_read_byte(rb);
      chk("sr_out_tc1", 16'(rb), 16'h009C);

      // simultaneous TI write and RPi load of TD ch0
      bus.r_rt = 1'b1; bus.r_dc = 1'b0; bus.r_sel = 2'd0;
      cyc(4);
      bus.ti_a = 16'h5FFF; bus.ti_d_in = 8'h5A;
      bus.ti_memen = 1'b0; bus.ti_we = 1'b0; bus.r_le = 1'b1;
      cyc(5);
      bus.ti_we = 1'b1; bus.ti_memen = 1'b1; bus.r_le = 1'b0;
      cyc(5);
      rpi_read_byte(rb);
      chk("coll_old", 16'(rb), 16'h00A5);
      ti_read("coll_new", 16'h5FFF, 1'b1, 8'h5A);

`ifdef TIPI_RC_IRQ_EN
      irq_en = 1'b1;
      cyc(3);
      chk("irq_idle", 16'(bus.ti_extint), 16'h1);
      rpi_shift_byte(8'h01);
      rpi_latch(1'b0, 1'b1, 2'd0);
      chk("irq_set", 16'(bus.ti_extint), 16'h0);
      ti_read("irq_rc0", 16'h5FF9, 1'b1, 8'h01);
      chk("irq_clr", 16'(bus.ti_extint), 16'h1);
      irq_en = 1'b0;
      rpi_latch(1'b0, 1'b1, 2'd0);
      chk("irq_masked", 16'(bus.ti_extint), 16'h1);
      irq_en = 1'b1;
      cyc(3);
      chk("irq_unmask", 16'(bus.ti_extint), 16'h0);
      ti_read("irq_rc0b", 16'h5FF9, 1'b1, 8'h01);
      chk("irq_clr2", 16'(bus.ti_extint), 16'h1);
      irq_en = 1'b0;
`else
      irq_en = 1'b1;
      rpi_shift_byte(8'h01);
      rpi_latch(1'b0, 1'b1, 2'd0);
      chk("noirq_ext", 16'(bus.ti_extint), 16'h1);
      irq_en = 1'b0;
`endif

      // reset mid-transfer clears immediately
      ti_write(16'h5FFD, 8'hFF);
      rpi_latch(1'b1, 1'b1, 2'd0);
      chk("pre_rst_rdin", 16'(bus.r_din), 16'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_rdin_async", 16'(bus.r_din), 16'h0);
      chk("rst_ext_async", 16'(bus.ti_extint), 16'h1);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      ti_read("rst_tc0", 16'h5FFD, 1'b1, 8'h00);
      ti_read("rst_rd1", 16'h5FF3, 1'b1, 8'h00);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
